// File: rtl/cr16_pkg.sv
// Shared encodings for the CR16 controller: FSM states, instruction classes,
// ALU opcodes, branch condition codes and flag bit positions.
package cr16_pkg;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_DECODE  = 2'd1,
      ST_EXECUTE = 2'd2,
      ST_HALT    = 2'd3
   } state_t;

   localparam logic [3:0] CLS_ALU   = 4'h0;
   localparam logic [3:0] CLS_ADDI  = 4'h1;
   localparam logic [3:0] CLS_BCOND = 4'hC;
   localparam logic [3:0] CLS_HALT  = 4'hF;

   localparam logic [3:0] ALU_OP_ADD = 4'h1;
   localparam logic [3:0] ALU_OP_CMP = 4'h7;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_HI = 4'h4;
   localparam logic [3:0] COND_LS = 4'h5;
   localparam logic [3:0] COND_GT = 4'h6;
   localparam logic [3:0] COND_LE = 4'h7;
   localparam logic [3:0] COND_UC = 4'hE;

   localparam int FLAG_C = 0;
   localparam int FLAG_L = 1;
   localparam int FLAG_F = 2;
   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 4;

   function automatic logic [15:0] sext8(input logic [7:0] value);
      return {{8{value[7]}}, value};
   endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Branch condition evaluator: decides whether a Bcond is taken from its
// 4-bit condition field and the datapath flag register.
module cr16_cond_eval
   import cr16_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] flags,
   output logic       taken
);

   // The F flag plays no part in any branch condition.
   logic unused_flag_f;
   assign unused_flag_f = flags[FLAG_F];

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken = flags[FLAG_Z];
         COND_NE: taken = ~flags[FLAG_Z];
         COND_CS: taken = flags[FLAG_C];
         COND_CC: taken = ~flags[FLAG_C];
         COND_HI: taken = flags[FLAG_L];
         COND_LS: taken = ~flags[FLAG_L];
         COND_GT: taken = flags[FLAG_N];
         COND_LE: taken = ~flags[FLAG_N];
         COND_UC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cr16_controller.sv
// Three-cycle FETCH/DECODE/EXECUTE controller for the CR16 datapath; all
// outputs come from registered state, IR and a registered reset flag.
module cr16_controller
   import cr16_pkg::*;
#(
   parameter logic [15:0] PC_RESET = 16'h0000
)(
   input  logic        I_CLK,
   input  logic        I_RESET,
   input  logic [15:0] I_INSTR,
   input  logic        I_INSTR_VALID,
   input  logic [4:0]  I_FLAGS,
   output logic        O_INSTR_READY,
   output logic [15:0] O_PC,
   output logic [15:0] O_REG_ENABLE,
   output logic [3:0]  O_OPCODE,
   output logic [3:0]  O_READ_PORT_A_SEL,
   output logic [3:0]  O_READ_PORT_B_SEL,
   output logic        O_ENABLE,
   output logic        O_IMM_SEL,
   output logic [15:0] O_IMM,
   output logic        O_ILLEGAL,
   output logic        O_HALTED
);

   state_t      state, state_next;
   logic [15:0] ir, ir_next;
   logic [15:0] pc, pc_next;
   logic        reset_q;
   logic        taken;
   logic [3:0]  ir_class;

   assign ir_class = ir[15:12];
   assign O_PC     = pc;

   cr16_cond_eval u_cond_eval (
      .cond  (ir[11:8]),
      .flags (I_FLAGS),
      .taken (taken)
   );

   // reset_q remembers that reset was sampled, so outputs can be held quiet
   // during reset without a combinational path from I_RESET.
   always_ff @(posedge I_CLK) begin
      reset_q <= I_RESET;
      if (I_RESET) begin
         state <= ST_FETCH;
         ir    <= 16'h0000;
         pc    <= PC_RESET;
      end else begin
         state <= state_next;
         ir    <= ir_next;
         pc    <= pc_next;
      end
   end

   always_comb begin
      state_next = state;
      ir_next    = ir;
      pc_next    = pc;
      case (state)
         ST_FETCH: begin
            if (I_INSTR_VALID && !reset_q) begin
               ir_next    = I_INSTR;
               state_next = ST_DECODE;
            end
         end
         ST_DECODE: state_next = ST_EXECUTE;
         ST_EXECUTE: begin
            state_next = ST_FETCH;
            pc_next    = pc + 16'd1;
            if (ir_class == CLS_BCOND && taken) begin
               pc_next = pc + sext8(ir[7:0]);
            end else if (ir_class == CLS_HALT) begin
               pc_next    = pc;
               state_next = ST_HALT;
            end
         end
         ST_HALT: state_next = ST_HALT;
         default: state_next = ST_FETCH;
      endcase
   end

   always_comb begin
      O_INSTR_READY     = 1'b0;
      O_REG_ENABLE      = 16'h0000;
      O_OPCODE          = 4'h0;
      O_READ_PORT_A_SEL = 4'h0;
      O_READ_PORT_B_SEL = 4'h0;
      O_ENABLE          = 1'b0;
      O_IMM_SEL         = 1'b0;
      O_IMM             = 16'h0000;
      O_ILLEGAL         = 1'b0;
      O_HALTED          = 1'b0;
      if (!reset_q) begin
         O_INSTR_READY = (state == ST_FETCH);
         O_HALTED      = (state == ST_HALT);
         if (state == ST_DECODE || state == ST_EXECUTE) begin
            case (ir_class)
               CLS_ALU: begin
                  O_OPCODE          = ir[7:4];
                  O_READ_PORT_A_SEL = ir[11:8];
                  O_READ_PORT_B_SEL = ir[3:0];
                  if (state == ST_EXECUTE) begin
                     O_ENABLE = 1'b1;
                     if (ir[7:4] != ALU_OP_CMP) begin
                        O_REG_ENABLE = 16'h0001 << ir[11:8];
                     end
                  end
               end
               CLS_ADDI: begin
                  O_OPCODE          = ALU_OP_ADD;
                  O_READ_PORT_A_SEL = ir[11:8];
                  O_IMM_SEL         = 1'b1;
                  O_IMM             = sext8(ir[7:0]);
                  if (state == ST_EXECUTE) begin
                     O_ENABLE     = 1'b1;
                     O_REG_ENABLE = 16'h0001 << ir[11:8];
                  end
               end
               CLS_BCOND, CLS_HALT: ;
               default: O_ILLEGAL = (state == ST_EXECUTE);
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cr16_controller.sv
// Directed bench for cr16_controller: ALU, ADDI, branches, wrap-around,
// illegal opcodes, halt and reset from mid-instruction and HALT.
module tb_cr16_controller;
   import cr16_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instr = 16'h0000;
   logic        instr_valid = 1'b0;
   logic [4:0]  flags = 5'b00000;
   logic        instr_ready;
   logic [15:0] pc;
   logic [15:0] reg_enable;
   logic [3:0]  opcode;
   logic [3:0]  sel_a;
   logic [3:0]  sel_b;
   logic        alu_enable;
   logic        imm_sel;
   logic [15:0] imm;
   logic        illegal;
   logic        halted;

   int checks = 0;
   int errors = 0;

   cr16_controller dut (
      .I_CLK             (clk),
      .I_RESET           (reset),
      .I_INSTR           (instr),
      .I_INSTR_VALID     (instr_valid),
      .I_FLAGS           (flags),
      .O_INSTR_READY     (instr_ready),
      .O_PC              (pc),
      .O_REG_ENABLE      (reg_enable),
      .O_OPCODE          (opcode),
      .O_READ_PORT_A_SEL (sel_a),
      .O_READ_PORT_B_SEL (sel_b),
      .O_ENABLE          (alu_enable),
      .O_IMM_SEL         (imm_sel),
      .O_IMM             (imm),
      .O_ILLEGAL         (illegal),
      .O_HALTED          (halted)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Present one instruction in FETCH and step into DECODE.
   task automatic apply_stimulus(input logic [15:0] word);
      instr       = word;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
   endtask

   // Run a branch from DECODE through to FETCH and check the new PC.
   task automatic run_branch(input string tag, input logic [15:0] word,
                             input logic [4:0] flag_val, input logic [15:0] pc_exp);
      flags = flag_val;
      apply_stimulus(word);
      tick();
      check_output({tag, "_en"}, {15'b0, alu_enable}, 16'h0000);
      check_output({tag, "_we"}, reg_enable, 16'h0000);
      tick();
      check_output({tag, "_pc"}, pc, pc_exp);
   endtask

   task automatic check_quiet(input string tag);
      check_output({tag, "_rdy"}, {15'b0, instr_ready}, 16'h0000);
      check_output({tag, "_we"}, reg_enable, 16'h0000);
      check_output({tag, "_en"}, {15'b0, alu_enable}, 16'h0000);
      check_output({tag, "_ill"}, {15'b0, illegal}, 16'h0000);
      check_output({tag, "_hlt"}, {15'b0, halted}, 16'h0000);
      check_output({tag, "_isel"}, {15'b0, imm_sel}, 16'h0000);
      check_output({tag, "_imm"}, imm, 16'h0000);
      check_output({tag, "_op"}, {12'b0, opcode}, 16'h0000);
      check_output({tag, "_sa"}, {12'b0, sel_a}, 16'h0000);
      check_output({tag, "_sb"}, {12'b0, sel_b}, 16'h0000);
   endtask

   initial begin
      // Reset held for two edges: everything quiet, PC at reset value.
      tick();
      tick();
      check_quiet("rst");
      check_output("rst_pc", pc, 16'h0000);
      reset = 1'b0;
      tick();
      check_output("post_rst_rdy", {15'b0, instr_ready}, 16'h0001);

      // ALU op with instr_valid held high and a HALT word on the bus.
      apply_stimulus(16'h0153);
      instr_valid = 1'b1;
      instr       = 16'hF000;
      check_output("alu_dec_rdy", {15'b0, instr_ready}, 16'h0000);
      check_output("alu_dec_sa", {12'b0, sel_a}, 16'h0001);
      check_output("alu_dec_sb", {12'b0, sel_b}, 16'h0003);
      check_output("alu_dec_en", {15'b0, alu_enable}, 16'h0000);
      check_output("alu_dec_we", reg_enable, 16'h0000);
      tick();
      check_output("alu_ex_we", reg_enable, 16'h0002);
      check_output("alu_ex_op", {12'b0, opcode}, 16'h0005);
      check_output("alu_ex_sa", {12'b0, sel_a}, 16'h0001);
      check_output("alu_ex_sb", {12'b0, sel_b}, 16'h0003);
      check_output("alu_ex_en", {15'b0, alu_enable}, 16'h0001);
      check_output("alu_ex_isel", {15'b0, imm_sel}, 16'h0000);
      tick();
      instr_valid = 1'b0;
      check_output("alu_pc", pc, 16'h0001);
      check_output("alu_rdy", {15'b0, instr_ready}, 16'h0001);

      // ADDI R2, -1
      apply_stimulus(16'h12FF);
      check_output("addi_imm", imm, 16'hFFFF);
      check_output("addi_isel", {15'b0, imm_sel}, 16'h0001);
      check_output("addi_op", {12'b0, opcode}, {12'b0, ALU_OP_ADD});
      check_output("addi_sa", {12'b0, sel_a}, 16'h0002);
      tick();
      check_output("addi_we", reg_enable, 16'h0004);
      check_output("addi_en", {15'b0, alu_enable}, 16'h0001);
      tick();
      check_output("addi_pc", pc, 16'h0002);

      // CMP updates flags but writes no register.
      apply_stimulus({4'h0, 4'h0, ALU_OP_CMP, 4'h1});
      tick();
      check_output("cmp_we", reg_enable, 16'h0000);
      check_output("cmp_en", {15'b0, alu_enable}, 16'h0001);
      tick();
      check_output("cmp_pc", pc, 16'h0003);

      // Branches: move to 0x0010, then EQ taken / not taken and assorted codes.
      run_branch("uc_a", 16'hCE0D, 5'b00000, 16'h0010);
      run_branch("eq_t", 16'hC0FC, 5'b01000, 16'h000C);
      run_branch("uc_b", 16'hCE04, 5'b00000, 16'h0010);
      run_branch("eq_n", 16'hC0FC, 5'b00000, 16'h0011);
      run_branch("c9_n", 16'hC9FC, 5'b11111, 16'h0012);
      run_branch("ne_t", 16'hC102, 5'b00000, 16'h0014);
      run_branch("cs_n", 16'hC205, 5'b00000, 16'h0015);
      run_branch("gt_t", 16'hC6FF, 5'b10000, 16'h0014);
      run_branch("le_n", 16'hC7FF, 5'b10000, 16'h0015);
      run_branch("hi_t", 16'hC403, 5'b00010, 16'h0018);
      run_branch("wrap_dn", 16'hCEE7, 5'b00000, 16'hFFFF);

      // PC+1 wraps from 0xFFFF to 0x0000.
      apply_stimulus(16'h0000);
      tick();
      check_output("r0_we", reg_enable, 16'h0001);
      tick();
      check_output("wrap_up_pc", pc, 16'h0000);

      // Undefined class: single-cycle illegal pulse, no write, PC+1.
      apply_stimulus(16'h7000);
      check_output("ill_dec", {15'b0, illegal}, 16'h0000);
      tick();
      check_output("ill_ex", {15'b0, illegal}, 16'h0001);
      check_output("ill_we", reg_enable, 16'h0000);
      check_output("ill_en", {15'b0, alu_enable}, 16'h0000);
      tick();
      check_output("ill_after", {15'b0, illegal}, 16'h0000);
      check_output("ill_pc", pc, 16'h0001);

      // Reset while in DECODE.
      apply_stimulus(16'h0153);
      reset = 1'b1;
      tick();
      check_quiet("rst_dec");
      check_output("rst_dec_pc", pc, 16'h0000);
      reset = 1'b0;
      tick();
      check_output("rst_dec_rdy", {15'b0, instr_ready}, 16'h0001);
      check_output("rst_dec_we", reg_enable, 16'h0000);

      // HALT, then ten cycles of valid instructions must not wake it.
      apply_stimulus(16'hF000);
      tick();
      check_output("halt_ex", {15'b0, halted}, 16'h0000);
      tick();
      check_output("halt_on", {15'b0, halted}, 16'h0001);
      check_output("halt_rdy", {15'b0, instr_ready}, 16'h0000);
      check_output("halt_pc", pc, 16'h0000);
      instr_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         instr = 16'h0153 + 16'(i);
         tick();
         check_output("halt_stay", {15'b0, halted}, 16'h0001);
         check_output("halt_we", reg_enable, 16'h0000);
      end
      check_output("halt_pc_end", pc, 16'h0000);
      instr_valid = 1'b0;

      // Reset out of HALT.
      reset = 1'b1;
      tick();
      check_quiet("rst_hlt");
      check_output("rst_hlt_pc", pc, 16'h0000);
      reset = 1'b0;
      tick();
      check_output("rst_hlt_rdy", {15'b0, instr_ready}, 16'h0001);
      check_output("rst_hlt_hlt", {15'b0, halted}, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
